pcs_rx_data_packer: RTL and testbench
=====================================

Name: pcs_rx_data_packer

Overview:
- Receive-side counterpart of the TX PIPE data-bus splitter.
- Takes decoded 8-bit symbols (data, K flag, error flags) one byte per strobe and aligns the byte stream to COM (K28.5).
- Packs 1/2/4 symbols into the PIPE RX_Data/RX_DataK word selected by DataBusWidth, and generates RX_Valid and RX_Status.
- Sits between the 8b/10b decoder / elastic buffer output and the MAC interface, entirely in the PCLK domain.

Parameters:
COM_SYM, 8'hBC, K-code that starts word alignment (K28.5)
EDB_SYM, 8'hFE, substitute byte for a symbol with decode error (K30.7, K=1)

Ports:
PCLK  input  1  single clock for the block
RST  input  1  asynchronous, active-high reset
DataBusWidth  input  6  6'd8 / 6'd16 / 6'd32; any other value means 32
Comma_Lock  input  1  symbol aligner has lock
Sym_Valid  input  1  Sym_* inputs carry a symbol this cycle
Sym_Data  input  8  decoded byte
Sym_DataK  input  1  byte is a K-code
Sym_DecErr  input  1  8b/10b code violation on this symbol
Sym_DispErr  input  1  running-disparity error on this symbol
RX_Data  output  32  packed word; first-received byte in [7:0]
RX_DataK  output  4  per-byte K flags, bit i pairs with RX_Data[8i+7:8i]
RX_Valid  output  1  packer aligned and delivering words
RX_Status  output  3  PIPE status of the word currently on RX_Data
Word_Strobe  output  1  one-cycle pulse: new word on RX_Data/RX_DataK/RX_Status

Behaviour:
- Reset: all outputs 0; FSM = UNLOCKED; byte count 0; latched width 32; accumulators cleared.
- FSM UNLOCKED: ignore symbols. Comma_Lock=1 -> SEEK.
- FSM SEEK: wait for Sym_Valid with Sym_Data==COM_SYM and Sym_DataK=1.
  - On that COM: latch width from DataBusWidth, store COM as byte 0, count=1, -> PACK.
  - If width is 8, the COM itself completes a word.
- FSM PACK: each Sym_Valid stores the byte at lane=count and increments count.
  - When count reaches N-1 (N = 1/2/4 bytes) and Sym_Valid, the word completes.
  - Next cycle: RX_Data, RX_DataK, RX_Status update; Word_Strobe=1 for exactly one cycle; count wraps to 0.
- Latency: last byte sampled in cycle T -> word visible in T+1. Outputs hold between strobes.
- RX_Valid: set together with the first Word_Strobe after entering PACK. Cleared the cycle after Comma_Lock is sampled 0.
- Comma_Lock=0 in any state -> UNLOCKED next cycle; partial word discarded, no strobe.
  - Lock loss in the same cycle as a word-completing byte: lock loss wins, no strobe.
- RX_Data/RX_DataK keep their last value after lock loss; RX_Status cleared to 000.
- DataBusWidth changes in PACK are ignored; width is re-latched only on the COM in SEEK.
- Error handling, per byte:
  - Sym_DecErr: byte stored as EDB_SYM with K=1.
  - Sym_DispErr: byte data kept unchanged.
- RX_Status accumulates over the bytes of one word:
  - 3'b100 if any byte had a decode error (highest priority);
  - else 3'b111 if any byte had a disparity error;
  - else 3'b000.
- Unused upper lanes (width 8/16) are driven 0 in RX_Data and RX_DataK.
- Sym_Valid=0 cycles are gaps: count holds, no side effects.

Optional Feature:
- COM_REALIGN_EN defined: in PACK, a COM arriving at lane != 0 drops the partial word (no strobe) and restarts the word with that COM at lane 0, count=1.
  - RX_Status of the next emitted word = 3'b100 to flag the realign.
- COM_REALIGN_EN undefined: a COM in PACK is packed like any other byte.

Test Plan:
- Width 32, lock, stream BC(K) 11 22 33 -> one strobe one cycle after byte 33; RX_Data=32'h332211BC, RX_DataK=4'b0001, RX_Status=000, RX_Valid=1.
- Width 16, stream BC(K) 11 22 33, with 2 idle cycles between bytes -> strobes: 16'h11BC/K=01, then 16'h3322/K=00; upper 16 bits 0; no strobe during gaps.
- Width 8, bytes 00 55 before first COM, then BC(K) 5A -> no strobe for 00/55; strobes RX_Data=BC (K=1), then 5A (K=0).
- Width 32, word BC 11 22 33 with DispErr on 11 and DecErr on 22 -> RX_Data=32'h33FE11BC, RX_DataK=4'b0101, RX_Status=3'b100.
- Width 32, drop Comma_Lock in the cycle 33 is presented -> no strobe, RX_Valid=0 next cycle, RX_Status=000. Relock; BC 44 55 66 -> word 32'h665544BC.
- COM_REALIGN_EN defined, width 32: BC 11 BC 22 33 44 -> first partial word dropped; word 32'h443322BC with RX_Status=3'b100. Without the macro -> word 32'h22BC11BC, status 000.

Source files
------------

// File: rtl/pcs_rx_data_packer.sv
// pcs_rx_data_packer
//   Receive-side PIPE data-bus packer. Accepts decoded 8b/10b symbols one
//   byte per Sym_Valid strobe, aligns the byte stream to COM (K28.5), and
//   packs 1/2/4 bytes into RX_Data/RX_DataK according to DataBusWidth.
//   Generates RX_Valid, RX_Status and a one-cycle Word_Strobe per word.
//
// Ports
//   PCLK         single clock for the block
//   RST          asynchronous, active-high reset
//   DataBusWidth 8/16/32 (any other value means 32); latched on the aligning COM
//   Comma_Lock   symbol aligner lock; dropping it discards any partial word
//   Sym_Valid    Sym_* carry a symbol this cycle
//   Sym_Data     decoded byte
//   Sym_DataK    byte is a K-code
//   Sym_DecErr   code violation: byte replaced by EDB_SYM with K=1
//   Sym_DispErr  running-disparity error: byte kept, status flagged
//   RX_Data      packed word, first-received byte in [7:0], unused lanes 0
//   RX_DataK     per-byte K flags
//   RX_Valid     aligned and delivering words
//   RX_Status    PIPE status of the word on RX_Data
//   Word_Strobe  one-cycle pulse when a new word is presented
//
// Build option
//   COM_REALIGN_EN: a COM seen at a non-zero lane while packing drops the
//   partial word and restarts alignment on that COM; the next word reports
//   status 3'b100.

module pcs_rx_data_packer #(
    parameter logic [7:0] COM_SYM = 8'hBC,
    parameter logic [7:0] EDB_SYM = 8'hFE
) (
    input  logic        PCLK,
    input  logic        RST,
    input  logic [5:0]  DataBusWidth,
    input  logic        Comma_Lock,
    input  logic        Sym_Valid,
    input  logic [7:0]  Sym_Data,
    input  logic        Sym_DataK,
    input  logic        Sym_DecErr,
    input  logic        Sym_DispErr,
    output logic [31:0] RX_Data,
    output logic [3:0]  RX_DataK,
    output logic        RX_Valid,
    output logic [2:0]  RX_Status,
    output logic        Word_Strobe
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SEEK     = 2'd1,
        ST_PACK     = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  count;
    logic [1:0]  last_lane;
    logic [31:0] acc_data;
    logic [3:0]  acc_k;
    logic        acc_dec;
    logic        acc_disp;
    logic        acc_realign;

    logic        is_com;
    logic        take;
    logic        realign;
    logic        fresh;
    logic        complete;
    logic [1:0]  lane;
    logic [1:0]  eff_last;
    logic [7:0]  byte_d;
    logic        byte_k;
    logic [31:0] new_data;
    logic [3:0]  new_k;
    logic        new_dec;
    logic        new_disp;
    logic        new_realign;

    // Index of the last lane of a word for a given bus width.
    function automatic logic [1:0] width_last_lane(input logic [5:0] w);
        case (w)
            6'd8:    return 2'd0;
            6'd16:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Decode errors (and realign events) outrank disparity errors.
    function automatic logic [2:0] word_status(input logic dec, input logic disp);
        if (dec)
            return 3'b100;
        else if (disp)
            return 3'b111;
        else
            return 3'b000;
    endfunction

    always_comb begin
        is_com   = Sym_Valid && Sym_DataK && (Sym_Data == COM_SYM);
        byte_d   = Sym_DecErr ? EDB_SYM : Sym_Data;
        byte_k   = Sym_DecErr | Sym_DataK;
        take     = Comma_Lock && Sym_Valid &&
                   (((state == ST_SEEK) && is_com) || (state == ST_PACK));
`ifdef COM_REALIGN_EN
        realign  = (state == ST_PACK) && is_com && (count != 2'd0);
`else
        realign  = 1'b0;
`endif
        // A word starts from empty accumulators on the aligning COM or a realign.
        fresh    = (state == ST_SEEK) || realign;
        eff_last = (state == ST_SEEK) ? width_last_lane(DataBusWidth) : last_lane;
        lane     = fresh ? 2'd0 : count;

        new_data = fresh ? 32'd0 : acc_data;
        new_k    = fresh ? 4'd0 : acc_k;
        new_data[{lane, 3'b000} +: 8] = byte_d;
        new_k[lane]  = byte_k;
        new_dec      = (fresh ? 1'b0 : acc_dec) | Sym_DecErr;
        new_disp     = (fresh ? 1'b0 : acc_disp) | Sym_DispErr;
        new_realign  = realign | (fresh ? 1'b0 : acc_realign);
        complete     = take && (lane == eff_last);
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state       <= ST_UNLOCKED;
            count       <= 2'd0;
            last_lane   <= 2'd3;
            acc_data    <= 32'd0;
            acc_k       <= 4'd0;
            acc_dec     <= 1'b0;
            acc_disp    <= 1'b0;
            acc_realign <= 1'b0;
            RX_Data     <= 32'd0;
            RX_DataK    <= 4'd0;
            RX_Valid    <= 1'b0;
            RX_Status   <= 3'b000;
            Word_Strobe <= 1'b0;
        end else begin
            Word_Strobe <= 1'b0;
            if (!Comma_Lock) begin
                // Lock loss wins over everything, including a completing byte.
                state       <= ST_UNLOCKED;
                count       <= 2'd0;
                acc_data    <= 32'd0;
                acc_k       <= 4'd0;
                acc_dec     <= 1'b0;
                acc_disp    <= 1'b0;
                acc_realign <= 1'b0;
                RX_Valid    <= 1'b0;
                RX_Status   <= 3'b000;
            end else if (state == ST_UNLOCKED) begin
                state <= ST_SEEK;
            end else if (take) begin
                if (state == ST_SEEK) begin
                    last_lane <= width_last_lane(DataBusWidth);
                    state     <= ST_PACK;
                end
                if (complete) begin
                    RX_Data     <= new_data;
                    RX_DataK    <= new_k;
                    RX_Status   <= word_status(new_dec | new_realign, new_disp);
                    RX_Valid    <= 1'b1;
                    Word_Strobe <= 1'b1;
                    count       <= 2'd0;
                    acc_data    <= 32'd0;
                    acc_k       <= 4'd0;
                    acc_dec     <= 1'b0;
                    acc_disp    <= 1'b0;
                    acc_realign <= 1'b0;
                end else begin
                    count       <= lane + 2'd1;
                    acc_data    <= new_data;
                    acc_k       <= new_k;
                    acc_dec     <= new_dec;
                    acc_disp    <= new_disp;
                    acc_realign <= new_realign;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcs_rx_data_packer.sv
// Testbench for pcs_rx_data_packer: directed scenarios plus randomized
// symbol traffic, checked by a scoreboard fed from a byte-queue model.
module tb_pcs_rx_data_packer;

    logic        PCLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  DataBusWidth = 6'd32;
    logic        Comma_Lock = 1'b0;
    logic        Sym_Valid = 1'b0;
    logic [7:0]  Sym_Data = 8'h00;
    logic        Sym_DataK = 1'b0;
    logic        Sym_DecErr = 1'b0;
    logic        Sym_DispErr = 1'b0;
    logic [31:0] RX_Data;
    logic [3:0]  RX_DataK;
    logic        RX_Valid;
    logic [2:0]  RX_Status;
    logic        Word_Strobe;

    pcs_rx_data_packer dut (
        .PCLK(PCLK), .RST(RST), .DataBusWidth(DataBusWidth),
        .Comma_Lock(Comma_Lock), .Sym_Valid(Sym_Valid), .Sym_Data(Sym_Data),
        .Sym_DataK(Sym_DataK), .Sym_DecErr(Sym_DecErr), .Sym_DispErr(Sym_DispErr),
        .RX_Data(RX_Data), .RX_DataK(RX_DataK), .RX_Valid(RX_Valid),
        .RX_Status(RX_Status), .Word_Strobe(Word_Strobe)
    );

    always #5 PCLK = ~PCLK;

`ifdef COM_REALIGN_EN
    localparam bit REALIGN = 1'b1;
`else
    localparam bit REALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [2:0]  s;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_bytes[$];
    logic        m_ks[$];
    int          m_state = 0;   // 0 unlocked, 1 seeking COM, 2 packing
    int          m_n = 4;
    bit          m_dec = 0, m_disp = 0, m_rl = 0;
    logic        exp_valid = 1'b0;
    logic        exp_strobe = 1'b0;
    logic [2:0]  exp_status = 3'b000;
    bit          mon_en = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic m_clear();
        m_bytes.delete();
        m_ks.delete();
        m_dec = 0;
        m_disp = 0;
        m_rl = 0;
    endtask

    // Reference model: one call per sampled clock edge with the sampled inputs.
    task automatic model(input bit lock, input bit v, input logic [7:0] d, input bit k,
                         input bit dec, input bit disp, input logic [5:0] w);
        exp_t e;
        bit   com;
        exp_strobe = 1'b0;
        if (!lock) begin
            m_state = 0;
            m_clear();
            exp_valid = 1'b0;
            exp_status = 3'b000;
            return;
        end
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (!v) return;
        com = k && (d == 8'hBC);
        if (m_state == 1) begin
            if (!com) return;
            m_n = (w == 6'd8) ? 1 : (w == 6'd16) ? 2 : 4;
            m_state = 2;
            m_clear();
        end else if (REALIGN && com && m_bytes.size() != 0) begin
            m_clear();
            m_rl = 1;
        end
        m_bytes.push_back(dec ? 8'hFE : d);
        m_ks.push_back(dec ? 1'b1 : k);
        m_dec |= dec;
        m_disp |= disp;
        if (m_bytes.size() == m_n) begin
            e.d = 32'd0;
            e.k = 4'd0;
            for (int i = 0; i < m_n; i++) begin
                e.d = e.d | (32'(m_bytes[i]) << (8 * i));
                e.k[i] = m_ks[i];
            end
            e.s = (m_dec || m_rl) ? 3'b100 : (m_disp ? 3'b111 : 3'b000);
            exp_q.push_back(e);
            exp_valid = 1'b1;
            exp_status = e.s;
            exp_strobe = 1'b1;
            m_clear();
        end
    endtask

    task automatic step(input bit lock, input bit v, input logic [7:0] d, input bit k,
                        input bit dec = 0, input bit disp = 0);
        Comma_Lock = lock;
        Sym_Valid = v;
        Sym_Data = d;
        Sym_DataK = k;
        Sym_DecErr = dec;
        Sym_DispErr = disp;
        @(posedge PCLK);
        model(lock, v, d, k, dec, disp, DataBusWidth);
        #1;
    endtask

    task automatic sym(input logic [7:0] d, input bit k = 0);
        step(1, 1, d, k);
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0);
    endtask

    // Monitor: per-cycle control outputs plus scoreboard pop on every word.
    always @(negedge PCLK) begin
        if (mon_en) begin
            exp_t e;
            check("rx_valid", 32'(RX_Valid), 32'(exp_valid));
            check("rx_status_hold", 32'(RX_Status), 32'(exp_status));
            check("word_strobe", 32'(Word_Strobe), 32'(exp_strobe));
            if (Word_Strobe) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %h expected no word (t=%0t)", RX_Data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", RX_Data, e.d);
                    check("word_datak", 32'(RX_DataK), 32'(e.k));
                    check("word_status", 32'(RX_Status), 32'(e.s));
                end
            end
        end
    end

    initial begin
        logic [5:0] widths [5];
        widths[0] = 6'd8; widths[1] = 6'd16; widths[2] = 6'd32;
        widths[3] = 6'd0; widths[4] = 6'd63;

        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_data", RX_Data, 32'd0);
        check("reset_datak", 32'(RX_DataK), 32'd0);
        check("reset_valid", 32'(RX_Valid), 32'd0);
        check("reset_status", 32'(RX_Status), 32'd0);
        check("reset_strobe", 32'(Word_Strobe), 32'd0);
        RST = 1'b0;
        mon_en = 1;

        // Width 32 basic word
        DataBusWidth = 6'd32;
        idle(2);
        sym(8'hBC, 1); sym(8'h11); sym(8'h22); sym(8'h33);
        check("t1_data", RX_Data, 32'h332211BC);
        check("t1_datak", 32'(RX_DataK), 32'h1);
        check("t1_valid", 32'(RX_Valid), 32'h1);
        idle(2);

        // Width 16 with gaps
        step(0, 0, 8'h00, 0);
        DataBusWidth = 6'd16;
        idle(1);
        sym(8'hBC, 1); idle(2); sym(8'h11);
        check("t2_word0", RX_Data, 32'h000011BC);
        idle(2); sym(8'h22); idle(2); sym(8'h33);
        check("t2_word1", RX_Data, 32'h00003322);
        check("t2_datak", 32'(RX_DataK), 32'h0);
        idle(2);

        // Width 8, bytes before COM ignored
        step(0, 0, 8'h00, 0);
        DataBusWidth = 6'd8;
        idle(1);
        sym(8'h00); sym(8'h55); sym(8'hBC, 1);
        check("t3_com", RX_Data, 32'h000000BC);
        check("t3_comk", 32'(RX_DataK), 32'h1);
        sym(8'h5A);
        check("t3_data", RX_Data, 32'h0000005A);
        idle(1);

        // Error substitution and status priority
        step(0, 0, 8'h00, 0);
        DataBusWidth = 6'd32;
        idle(1);
        sym(8'hBC, 1);
        step(1, 1, 8'h11, 0, 0, 1);
        step(1, 1, 8'h22, 0, 1, 0);
        sym(8'h33);
        check("t4_data", RX_Data, 32'h33FE11BC);
        check("t4_datak", 32'(RX_DataK), 32'b0101);
        check("t4_status", 32'(RX_Status), 32'b100);

        // Lock loss on the completing byte
        sym(8'hBC, 1); sym(8'h11); sym(8'h22);
        step(0, 1, 8'h33, 0);
        check("t5_valid_drop", 32'(RX_Valid), 32'h0);
        check("t5_status_clr", 32'(RX_Status), 32'h0);
        check("t5_data_hold", RX_Data, 32'h33FE11BC);
        idle(1);
        sym(8'hBC, 1); sym(8'h44); sym(8'h55); sym(8'h66);
        check("t5_relock", RX_Data, 32'h665544BC);

        // COM inside a word
        sym(8'hBC, 1); sym(8'h11); sym(8'hBC, 1); sym(8'h22); sym(8'h33); sym(8'h44);
`ifdef COM_REALIGN_EN
        check("t6_data", RX_Data, 32'h443322BC);
        check("t6_status", 32'(RX_Status), 32'b100);
`else
        check("t6_data", RX_Data, 32'h22BC11BC);
        check("t6_status", 32'(RX_Status), 32'b000);
`endif
        step(0, 0, 8'h00, 0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit         lock, v, k, dec, disp;
            logic [7:0] d;
            if ($urandom_range(0, 99) == 0) DataBusWidth = widths[$urandom_range(0, 4)];
            lock = ($urandom_range(0, 79) != 0);
            v    = ($urandom_range(0, 9) < 7);
            d    = ($urandom_range(0, 5) == 0) ? 8'hBC : 8'($urandom);
            k    = (d == 8'hBC) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            dec  = ($urandom_range(0, 15) == 0);
            disp = ($urandom_range(0, 15) == 0);
            step(lock, v, d, k, dec, disp);
        end
        step(0, 0, 8'h00, 0);
        idle(2);
        @(negedge PCLK);
        #1;
        mon_en = 0;
        check("leftover_words", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
